apb_master_bridge: RTL and testbench

- Initiator-side APB bridge for the watermarking datapath: takes single-word read/write commands from the internal controller and drives APB signals to the memory/register slave.
- Runs the IDLE -> SETUP -> ACCESS sequence, holds in ACCESS until PREADY, and returns read data on a one-cycle response strobe.
- Allows back-to-back transfers with no idle cycle between them.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_master_bridge.sv | 138 +++++++++++++
 tb/tb_apb_master_bridge.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared state encoding and default sizes for the APB initiator bridge
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_t;

  localparam int AMBA_ADDR_DEPTH    = 20;
  localparam int AMBA_WORD          = 16;
  localparam int TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-word APB initiator with back-to-back transfers
// Optional ACCESS-phase watchdog enabled by APB_TIMEOUT_EN.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int amba_addr_depth = AMBA_ADDR_DEPTH,
  parameter int amba_word       = AMBA_WORD,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [amba_addr_depth-1:0] cmd_addr,
  input  logic [amba_word-1:0]       cmd_wdata,
  output logic                       rsp_valid,
  output logic [amba_word-1:0]       rsp_rdata,
  output logic                       rsp_err,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [amba_addr_depth-1:0] PADDR,
  output logic [amba_word-1:0]       PWDATA,
  input  logic [amba_word-1:0]       PRDATA,
  input  logic                       PREADY
);

  apb_state_t                 state_q, state_d;
  logic                       pwrite_q, pwrite_d;
  logic [amba_addr_depth-1:0] paddr_q, paddr_d;
  logic [amba_word-1:0]       pwdata_q, pwdata_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic                       rsp_err_q, rsp_err_d;
  logic [amba_word-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                       accept;
  logic                       done;
  logic                       timeout_hit;

  // A new command may be taken while the current one completes, giving 2-cycle throughput.
  assign cmd_ready = (state_q == IDLE) || ((state_q == ACCESS) && PREADY);
  assign accept    = cmd_valid && cmd_ready;
  assign done      = (state_q == ACCESS) && (PREADY || timeout_hit);

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter is zero outside ACCESS, so it is already clear on every entry to ACCESS.
  always_comb begin
    cnt_d = '0;
    if ((state_q == ACCESS) && !PREADY) cnt_d = cnt_q + CNT_W'(1);
  end

  assign timeout_hit = (state_q == ACCESS) && !PREADY && (cnt_q == CNT_LAST);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept) state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (PREADY)           state_d = accept ? SETUP : IDLE;
        else if (timeout_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    case (state_q)
      SETUP:  PSEL = 1'b1;
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
      end
      default: ;
    endcase
  end

  // Bus fields only move on accept, so they stay stable across SETUP and all ACCESS cycles.
  always_comb begin
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = done;
    rsp_err_d   = timeout_hit;
    rsp_rdata_d = rsp_rdata_q;
    if (accept) begin
      pwrite_d = cmd_write;
      paddr_d  = cmd_addr;
      pwdata_d = cmd_write ? cmd_wdata : '0;
    end
    if (done) rsp_rdata_d = (pwrite_q || timeout_hit) ? '0 : PRDATA;
  end

  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - self-checking bench for apb_master_bridge
module tb_apb_master_bridge;

  localparam int AW = 20;
  localparam int DW = 16;
`ifdef APB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic          PCLK;
  logic          PRESETn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [16:0] sb[$];
  logic [16:0] exp_r;

  apb_master_bridge #(
    .amba_addr_depth(AW),
    .amba_word      (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  task automatic test_reset();
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    PRDATA = '0; PREADY = 1'b1;
    repeat (2) @(negedge PCLK);
    n_total++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) $display("FAIL reset_ctrl got %b exp 000", {PSEL, PENABLE, PWRITE}); else n_pass++;
    n_total++; if ({rsp_valid, rsp_err} !== 2'b00) $display("FAIL reset_rsp got %b exp 00", {rsp_valid, rsp_err}); else n_pass++;
    n_total++; if ({PADDR, PWDATA, rsp_rdata} !== 52'h0) $display("FAIL reset_data got %h exp 0", {PADDR, PWDATA, rsp_rdata}); else n_pass++;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", cmd_ready); else n_pass++;
    PRESETn = 1'b1;
  endtask

  task automatic test_write();
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 20'h00123; cmd_wdata = 16'h00A5;
    PREADY = 1'b1; PRDATA = 16'h7777;
    #1;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL wr_ready got %b exp 1", cmd_ready); else n_pass++;
    sb.push_back({1'b0, 16'h0000});
    @(negedge PCLK); cmd_valid = 1'b0;
    n_total++; if ({PSEL, PENABLE} !== 2'b10) $display("FAIL wr_setup got %b exp 10", {PSEL, PENABLE}); else n_pass++;
    n_total++; if ({PWRITE, PADDR, PWDATA} !== {1'b1, 20'h00123, 16'h00A5}) $display("FAIL wr_setup_bus got %h exp %h", {PWRITE, PADDR, PWDATA}, {1'b1, 20'h00123, 16'h00A5}); else n_pass++;
    @(negedge PCLK);
    n_total++; if ({PSEL, PENABLE, rsp_valid} !== 3'b110) $display("FAIL wr_access got %b exp 110", {PSEL, PENABLE, rsp_valid}); else n_pass++;
    n_total++; if ({PWRITE, PADDR, PWDATA} !== {1'b1, 20'h00123, 16'h00A5}) $display("FAIL wr_access_bus got %h exp %h", {PWRITE, PADDR, PWDATA}, {1'b1, 20'h00123, 16'h00A5}); else n_pass++;
    @(negedge PCLK);
    n_total++; if ({PSEL, rsp_valid} !== 2'b01) $display("FAIL wr_done got %b exp 01", {PSEL, rsp_valid}); else n_pass++;
    if (rsp_valid === 1'b1) begin
      exp_r = sb.pop_front();
      n_total++; if ({rsp_err, rsp_rdata} !== exp_r) $display("FAIL wr_rsp got %h exp %h", {rsp_err, rsp_rdata}, exp_r); else n_pass++;
    end
    @(negedge PCLK);
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL wr_pulse got %b exp 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_read_wait();
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h00040; cmd_wdata = 16'h1234;
    PREADY = 1'b0; PRDATA = 16'h1111;
    #1;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL rd_ready got %b exp 1", cmd_ready); else n_pass++;
    sb.push_back({1'b0, 16'hBEEF});
    @(negedge PCLK); cmd_valid = 1'b0;
    n_total++; if ({PSEL, PENABLE, PWRITE, PWDATA} !== {3'b100, 16'h0}) $display("FAIL rd_setup got %h exp %h", {PSEL, PENABLE, PWRITE, PWDATA}, {3'b100, 16'h0}); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      n_total++; if ({PENABLE, PADDR, rsp_valid} !== {1'b1, 20'h00040, 1'b0}) $display("FAIL rd_access%0d got %h exp %h", i, {PENABLE, PADDR, rsp_valid}, {1'b1, 20'h00040, 1'b0}); else n_pass++;
      if (i == 3) begin PREADY = 1'b1; PRDATA = 16'hBEEF; end
      #1;
      n_total++; if (cmd_ready !== (i == 3)) $display("FAIL rd_wait_ready%0d got %b exp %b", i, cmd_ready, (i == 3)); else n_pass++;
    end
    @(negedge PCLK); PRDATA = 16'h2222;
    n_total++; if ({PSEL, rsp_valid} !== 2'b01) $display("FAIL rd_done got %b exp 01", {PSEL, rsp_valid}); else n_pass++;
    if (rsp_valid === 1'b1) begin
      exp_r = sb.pop_front();
      n_total++; if ({rsp_err, rsp_rdata} !== exp_r) $display("FAIL rd_rsp got %h exp %h", {rsp_err, rsp_rdata}, exp_r); else n_pass++;
    end
    @(negedge PCLK);
    n_total++; if ({rsp_valid, rsp_rdata} !== {1'b0, 16'hBEEF}) $display("FAIL rd_hold got %h exp %h", {rsp_valid, rsp_rdata}, {1'b0, 16'hBEEF}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 20'h00001; cmd_wdata = 16'h5A5A; PREADY = 1'b1;
    #1;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready0 got %b exp 1", cmd_ready); else n_pass++;
    sb.push_back({1'b0, 16'h0000});
    @(negedge PCLK);
    cmd_write = 1'b0; cmd_addr = 20'h00002; PRDATA = 16'hC0DE;
    n_total++; if ({PSEL, PENABLE, PWRITE, PADDR} !== {3'b101, 20'h00001}) $display("FAIL b2b_setup0 got %h exp %h", {PSEL, PENABLE, PWRITE, PADDR}, {3'b101, 20'h00001}); else n_pass++;
    @(negedge PCLK);
    n_total++; if ({PSEL, PENABLE, PADDR} !== {2'b11, 20'h00001}) $display("FAIL b2b_access0 got %h exp %h", {PSEL, PENABLE, PADDR}, {2'b11, 20'h00001}); else n_pass++;
    #1;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready1 got %b exp 1", cmd_ready); else n_pass++;
    sb.push_back({1'b0, 16'hC0DE});
    @(negedge PCLK); cmd_valid = 1'b0;
    n_total++; if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b100, 20'h00002, 16'h0}) $display("FAIL b2b_setup1 got %h exp %h", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b100, 20'h00002, 16'h0}); else n_pass++;
    n_total++; if (rsp_valid !== 1'b1) $display("FAIL b2b_rsp0_valid got %b exp 1", rsp_valid); else n_pass++;
    if (rsp_valid === 1'b1) begin
      exp_r = sb.pop_front();
      n_total++; if ({rsp_err, rsp_rdata} !== exp_r) $display("FAIL b2b_rsp0 got %h exp %h", {rsp_err, rsp_rdata}, exp_r); else n_pass++;
    end
    @(negedge PCLK);
    n_total++; if ({PSEL, PENABLE, rsp_valid} !== 3'b110) $display("FAIL b2b_access1 got %b exp 110", {PSEL, PENABLE, rsp_valid}); else n_pass++;
    @(negedge PCLK);
    n_total++; if ({PSEL, rsp_valid} !== 2'b01) $display("FAIL b2b_done1 got %b exp 01", {PSEL, rsp_valid}); else n_pass++;
    if (rsp_valid === 1'b1) begin
      exp_r = sb.pop_front();
      n_total++; if ({rsp_err, rsp_rdata} !== exp_r) $display("FAIL b2b_rsp1 got %h exp %h", {rsp_err, rsp_rdata}, exp_r); else n_pass++;
    end
  endtask

  task automatic test_reset_abort();
    logic got;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 20'h00077; cmd_wdata = 16'h0033; PREADY = 1'b0;
    @(negedge PCLK); cmd_valid = 1'b0;
    @(negedge PCLK);
    n_total++; if ({PSEL, PENABLE} !== 2'b11) $display("FAIL abort_access got %b exp 11", {PSEL, PENABLE}); else n_pass++;
    #2 PRESETn = 1'b0;
    #1;
    n_total++; if ({PSEL, PENABLE, PWRITE, rsp_valid, PADDR, PWDATA} !== 40'h0) $display("FAIL abort_async got %h exp 0", {PSEL, PENABLE, PWRITE, rsp_valid, PADDR, PWDATA}); else n_pass++;
    PREADY = 1'b1;
    @(negedge PCLK);
    n_total++; if ({rsp_valid, PSEL} !== 2'b00) $display("FAIL abort_norsp got %b exp 00", {rsp_valid, PSEL}); else n_pass++;
    PRESETn = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h00055; PRDATA = 16'h4242;
    #1;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL abort_ready got %b exp 1", cmd_ready); else n_pass++;
    sb.push_back({1'b0, 16'h4242});
    @(negedge PCLK); cmd_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge PCLK);
      if (rsp_valid === 1'b1) got = 1'b1;
    end
    n_total++; if (!got) $display("FAIL abort_recover got no rsp_valid exp rsp_valid within 10 cycles"); else n_pass++;
    if (got) begin
      exp_r = sb.pop_front();
      n_total++; if ({rsp_err, rsp_rdata} !== exp_r) $display("FAIL abort_rsp got %h exp %h", {rsp_err, rsp_rdata}, exp_r); else n_pass++;
    end
  endtask

  task automatic test_setup_hold();
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h00010; PREADY = 1'b1; PRDATA = 16'h0A0A;
    #1;
    sb.push_back({1'b0, 16'h0A0A});
    @(negedge PCLK);
    cmd_write = 1'b1; cmd_addr = 20'h00020; cmd_wdata = 16'h0099;
    #1;
    n_total++; if (cmd_ready !== 1'b0) $display("FAIL hold_setup_ready got %b exp 0", cmd_ready); else n_pass++;
    @(negedge PCLK);
    n_total++; if ({PWRITE, PADDR} !== {1'b0, 20'h00010}) $display("FAIL hold_not_latched got %h exp %h", {PWRITE, PADDR}, {1'b0, 20'h00010}); else n_pass++;
    #1;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL hold_access_ready got %b exp 1", cmd_ready); else n_pass++;
    sb.push_back({1'b0, 16'h0000});
    @(negedge PCLK); cmd_valid = 1'b0;
    n_total++; if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b101, 20'h00020, 16'h0099}) $display("FAIL hold_setup2 got %h exp %h", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b101, 20'h00020, 16'h0099}); else n_pass++;
    if (rsp_valid === 1'b1) begin
      exp_r = sb.pop_front();
      n_total++; if ({rsp_err, rsp_rdata} !== exp_r) $display("FAIL hold_rsp0 got %h exp %h", {rsp_err, rsp_rdata}, exp_r); else n_pass++;
    end else begin
      n_total++; $display("FAIL hold_rsp0_valid got 0 exp 1");
    end
    repeat (2) @(negedge PCLK);
    if (rsp_valid === 1'b1) begin
      exp_r = sb.pop_front();
      n_total++; if ({rsp_err, rsp_rdata} !== exp_r) $display("FAIL hold_rsp1 got %h exp %h", {rsp_err, rsp_rdata}, exp_r); else n_pass++;
    end else begin
      n_total++; $display("FAIL hold_rsp1_valid got 0 exp 1");
    end
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    logic got;
    int   n_acc;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h0003C; PREADY = 1'b0; PRDATA = 16'hFFFF;
    #1;
    sb.push_back({1'b1, 16'h0000});
    @(negedge PCLK); cmd_valid = 1'b0;
    got = 1'b0; n_acc = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge PCLK);
      if (PENABLE === 1'b1) n_acc++;
      if (rsp_valid === 1'b1) got = 1'b1;
    end
    n_total++; if (!got || n_acc != TO) $display("FAIL to_force got valid=%b access=%0d exp valid=1 access=%0d", got, n_acc, TO); else n_pass++;
    if (got) begin
      exp_r = sb.pop_front();
      n_total++; if ({rsp_err, rsp_rdata} !== exp_r) $display("FAIL to_rsp got %h exp %h", {rsp_err, rsp_rdata}, exp_r); else n_pass++;
      n_total++; if ({PSEL, cmd_ready} !== 2'b01) $display("FAIL to_idle got %b exp 01", {PSEL, cmd_ready}); else n_pass++;
    end
    cmd_valid = 1'b1; cmd_addr = 20'h0003D;
    #1;
    sb.push_back({1'b0, 16'h1357});
    @(negedge PCLK); cmd_valid = 1'b0;
    for (int i = 0; i < TO; i++) begin
      @(negedge PCLK);
      if (i == TO - 1) begin PREADY = 1'b1; PRDATA = 16'h1357; end
    end
    @(negedge PCLK);
    if (rsp_valid === 1'b1) begin
      exp_r = sb.pop_front();
      n_total++; if ({rsp_err, rsp_rdata} !== exp_r) $display("FAIL to_race got %h exp %h", {rsp_err, rsp_rdata}, exp_r); else n_pass++;
    end else begin
      n_total++; $display("FAIL to_race_valid got 0 exp 1");
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_reset_abort();
    test_setup_hold();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    @(negedge PCLK);
    n_total++; if (sb.size() != 0) $display("FAIL sb_drain got %0d pending exp 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
